// File: rtl/cache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_pkg: controller state type and line geometry for the datapath |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TAG_CHECK = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_RESPOND   = 3'd4
    } cache_state_t;

    localparam int unsigned C_LINE_BYTES = 32;
    localparam int unsigned C_OFFSET_W   = $clog2(C_LINE_BYTES);
    localparam int unsigned C_LINE_BITS  = C_LINE_BYTES * 8;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/plru_tree.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | plru_tree: combinational tree pseudo-LRU victim select and update    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         i_tree,
    input  logic [$clog2(WAYS)-1:0] i_access_way,
    output logic [$clog2(WAYS)-1:0] o_victim,
    output logic [WAYS-2:0]         o_tree_next
);

    localparam int LEVELS = $clog2(WAYS);

    // Heap-ordered nodes: children of node n are 2n+1 (lower half) and 2n+2.
    // A node bit of 1 means the victim lies in the upper half.
    always_comb begin : p_victim
        int node;
        int acc;
        node = 0;
        acc  = 0;
        for (int l = 0; l < LEVELS; l++) begin
            acc  = 2 * acc + int'(i_tree[node[LEVELS-1:0]]);
            node = 2 * node + 1 + int'(i_tree[node[LEVELS-1:0]]);
        end
        o_victim = acc[LEVELS-1:0];
    end

    always_comb begin : p_update
        int node;
        int dir;
        node        = 0;
        dir         = 0;
        o_tree_next = i_tree;
        for (int l = 0; l < LEVELS; l++) begin
            dir = (int'(i_access_way) >> (LEVELS - 1 - l)) & 1;
            o_tree_next[node[LEVELS-1:0]] = (dir == 0);
            node = 2 * node + 1 + dir;
        end
    end

endmodule : plru_tree
`default_nettype wire

// File: rtl/cache_control_nway.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cache_control_nway: N-way write-back/write-allocate cache control    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module cache_control_nway
    import cache_pkg::*;
#(
    parameter int WAYS     = 4,
    parameter int SETS     = 8,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5,
    parameter int CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_W-1:0]       mem_address,
    input  logic [WAYS-1:0]         hit,
    input  logic [WAYS-1:0]         valid,
    input  logic [WAYS-1:0]         dirty,
    input  logic                    pmem_resp,
    output logic                    mem_resp,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic                    pmem_address_sel,
    output logic [$clog2(WAYS)-1:0] way_sel,
    output logic [WAYS-1:0]         tag_load,
    output logic [WAYS-1:0]         valid_load,
    output logic [WAYS-1:0]         dirty_load,
    output logic                    dirty_datain,
    output logic [WAYS-1:0]         data_we,
    output logic                    data_datain_sel,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count,
    output logic [CNT_W-1:0]        wb_count
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SET_W = $clog2(SETS);

    cache_state_t         state_q, state_d;
    logic [WAY_W-1:0]     victim_q, victim_d;
    logic [WAYS-2:0]      plru_q [SETS];
    logic [WAYS-2:0]      plru_d [SETS];
    logic [CNT_W-1:0]     hit_count_q, hit_count_d;
    logic [CNT_W-1:0]     miss_count_q, miss_count_d;
    logic [CNT_W-1:0]     wb_count_q, wb_count_d;

    logic [SET_W-1:0]     w_set;
    logic                 w_is_write;
    logic                 w_any_hit;
    logic [WAY_W-1:0]     w_hit_way;
    logic                 w_has_invalid;
    logic [WAY_W-1:0]     w_inv_way;
    logic [WAY_W-1:0]     w_plru_victim;
    logic [WAY_W-1:0]     w_miss_victim;
    logic [WAY_W-1:0]     w_access_way;
    logic [WAYS-2:0]      w_tree_next;
    logic                 w_plru_we;
    logic                 w_hit_inc;
    logic                 w_miss_inc;
    logic                 w_wb_inc;
    logic [WAYS-1:0]      w_hit_oh;
    logic [WAYS-1:0]      w_victim_oh;

    assign w_set      = mem_address[OFFSET_W +: SET_W];
    wire   w_unused_addr = ^{mem_address[ADDR_W-1:OFFSET_W+SET_W], mem_address[OFFSET_W-1:0]};

    // Simultaneous read and write requests are serviced as a read.
    assign w_is_write = mem_write & ~mem_read;
    assign w_any_hit  = |hit;

    always_comb begin
        w_hit_way = '0;
        w_inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit[i])    w_hit_way = WAY_W'(i);
            if (!valid[i]) w_inv_way = WAY_W'(i);
        end
    end

    assign w_has_invalid = ~&valid;
    assign w_miss_victim = w_has_invalid ? w_inv_way : w_plru_victim;
    assign w_access_way  = (state_q == ST_RESPOND) ? victim_q : w_hit_way;
    assign w_hit_oh      = WAYS'(1) << w_hit_way;
    assign w_victim_oh   = WAYS'(1) << victim_q;

    plru_tree #(
        .WAYS (WAYS)
    ) u_plru_tree (
        .i_tree       (plru_q[w_set]),
        .i_access_way (w_access_way),
        .o_victim     (w_plru_victim),
        .o_tree_next  (w_tree_next)
    );

    always_comb begin
        state_d          = state_q;
        victim_d         = victim_q;
        w_plru_we        = 1'b0;
        w_hit_inc        = 1'b0;
        w_miss_inc       = 1'b0;
        w_wb_inc         = 1'b0;
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address_sel = 1'b0;
        way_sel          = '0;
        tag_load         = '0;
        valid_load       = '0;
        dirty_load       = '0;
        dirty_datain     = 1'b0;
        data_we          = '0;
        data_datain_sel  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) state_d = ST_TAG_CHECK;
            end
            ST_TAG_CHECK: begin
                if (w_any_hit) begin
                    mem_resp  = 1'b1;
                    way_sel   = w_hit_way;
                    w_plru_we = 1'b1;
                    w_hit_inc = 1'b1;
                    if (w_is_write) begin
                        data_we         = w_hit_oh;
                        data_datain_sel = 1'b1;
                        dirty_load      = w_hit_oh;
                        dirty_datain    = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    victim_d   = w_miss_victim;
                    w_miss_inc = 1'b1;
                    state_d    = (valid[w_miss_victim] && dirty[w_miss_victim])
                                 ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                pmem_write       = 1'b1;
                pmem_address_sel = 1'b1;
                way_sel          = victim_q;
                if (pmem_resp) begin
                    w_wb_inc = 1'b1;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_we    = w_victim_oh;
                    tag_load   = w_victim_oh;
                    valid_load = w_victim_oh;
                    dirty_load = w_victim_oh;
                    state_d    = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                mem_resp  = 1'b1;
                way_sel   = victim_q;
                w_plru_we = 1'b1;
                if (w_is_write) begin
                    data_we         = w_victim_oh;
                    data_datain_sel = 1'b1;
                    dirty_load      = w_victim_oh;
                    dirty_datain    = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        plru_d = plru_q;
        if (w_plru_we) plru_d[w_set] = w_tree_next;
    end

    // Event counters stick at all-ones rather than wrapping.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if (w_hit_inc  && hit_count_q  != '1) hit_count_d  = hit_count_q  + CNT_W'(1);
        if (w_miss_inc && miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
        if (w_wb_inc   && wb_count_q   != '1) wb_count_d   = wb_count_q   + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            victim_q     <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
            plru_q       <= plru_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;

endmodule : cache_control_nway
`default_nettype wire

// File: tb/tb_cache_control_nway.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cache_control_nway: directed transactions against a PLRU model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_cache_control_nway;

    localparam int WAYS  = 4;
    localparam int SETS  = 8;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, pmem_resp;
    logic [31:0] mem_address;
    logic [3:0]  hit, valid, dirty;
    logic        mem_resp, pmem_read, pmem_write, pmem_address_sel;
    logic [1:0]  way_sel;
    logic [3:0]  tag_load, valid_load, dirty_load, data_we;
    logic        dirty_datain, data_datain_sel;
    logic [CNT_W-1:0] hit_count, miss_count, wb_count;

    cache_control_nway #(
        .WAYS(WAYS), .SETS(SETS), .ADDR_W(32), .OFFSET_W(5), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .hit(hit), .valid(valid), .dirty(dirty), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address_sel(pmem_address_sel), .way_sel(way_sel),
        .tag_load(tag_load), .valid_load(valid_load), .dirty_load(dirty_load),
        .dirty_datain(dirty_datain), .data_we(data_we),
        .data_datain_sel(data_datain_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: tree bits per set and event totals
    logic [WAYS-2:0] mtree [SETS];
    int m_hit, m_miss, m_wb;

    // Expected outputs for the current cycle
    logic       e_mem_resp, e_pmem_read, e_pmem_write, e_sel, e_ddin, e_dds;
    logic [1:0] e_way_sel;
    logic [3:0] e_tag, e_vload, e_dload, e_we;
    bit         chk_en = 0;

    // Values seen by the compare process, for literal checks
    logic [1:0] cap_way_sel;
    logic [3:0] cap_data_we, cap_dirty_load, cap_tag_load;
    int         fill_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    // Descend the tree by halving the way range; bit 1 selects the upper half.
    function automatic int model_victim(input int s);
        int lo = 0, hi = WAYS, node = 0;
        while (hi - lo > 1) begin
            int mid = (lo + hi) / 2;
            if (mtree[s][node]) begin node = 2 * node + 2; lo = mid; end
            else                begin node = 2 * node + 1; hi = mid; end
        end
        return lo;
    endfunction

    task automatic model_touch(input int s, input int w);
        int lo = 0, hi = WAYS, node = 0;
        while (hi - lo > 1) begin
            int mid = (lo + hi) / 2;
            if (w < mid) begin mtree[s][node] = 1'b1; node = 2 * node + 1; hi = mid; end
            else         begin mtree[s][node] = 1'b0; node = 2 * node + 2; lo = mid; end
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic clear_exp();
        e_mem_resp = 0; e_pmem_read = 0; e_pmem_write = 0; e_sel = 0;
        e_ddin = 0; e_dds = 0; e_way_sel = 0;
        e_tag = 0; e_vload = 0; e_dload = 0; e_we = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_resp", mem_resp, e_mem_resp);
            check("pmem_read", pmem_read, e_pmem_read);
            check("pmem_write", pmem_write, e_pmem_write);
            check("pmem_address_sel", pmem_address_sel, e_sel);
            check("way_sel", way_sel, e_way_sel);
            check("tag_load", tag_load, e_tag);
            check("valid_load", valid_load, e_vload);
            check("dirty_load", dirty_load, e_dload);
            check("dirty_datain", dirty_datain, e_ddin);
            check("data_we", data_we, e_we);
            check("data_datain_sel", data_datain_sel, e_dds);
            check("hit_count", hit_count, sat(m_hit));
            check("miss_count", miss_count, sat(m_miss));
            check("wb_count", wb_count, sat(m_wb));
            if (mem_resp) begin
                cap_way_sel    = way_sel;
                cap_data_we    = data_we;
                cap_dirty_load = dirty_load;
            end
            if (pmem_read) fill_cyc++;
            if (pmem_read && pmem_resp) cap_tag_load = tag_load;
        end
    end

    // One CPU transaction, entered and left in an IDLE cycle at posedge+1.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [3:0] h, input logic [3:0] v, input logic [3:0] d,
                          input int wb_lat, input int fill_lat, input bit stray,
                          output int vict);
        int  s;
        bit  is_wr, dvict;
        s = int'(addr[7:5]);
        is_wr = wr && !rd;
        mem_read = rd; mem_write = wr; mem_address = addr;
        hit = h; valid = v; dirty = d; pmem_resp = stray;
        clear_exp();
        step();
        clear_exp();
        if (h != 4'b0) begin
            vict = lowest(h);
            e_mem_resp = 1; e_way_sel = 2'(vict);
            if (is_wr) begin
                e_we = 4'(1 << vict); e_dload = 4'(1 << vict); e_ddin = 1; e_dds = 1;
            end
            step();
            model_touch(s, vict);
            m_hit++;
        end else begin
            vict  = (lowest(~v) >= 0) ? lowest(~v) : model_victim(s);
            dvict = v[vict] && d[vict];
            step();
            m_miss++;
            valid = ~v; dirty = ~d; hit = 4'b0;
            if (dvict) begin
                for (int c = 1; c <= wb_lat; c++) begin
                    clear_exp();
                    e_pmem_write = 1; e_sel = 1; e_way_sel = 2'(vict);
                    pmem_resp = (c == wb_lat);
                    step();
                end
                m_wb++;
            end
            for (int c = 1; c <= fill_lat; c++) begin
                clear_exp();
                e_pmem_read = 1;
                pmem_resp = (c == fill_lat);
                if (c == fill_lat) begin
                    e_we = 4'(1 << vict); e_tag = 4'(1 << vict);
                    e_vload = 4'(1 << vict); e_dload = 4'(1 << vict);
                end
                step();
            end
            pmem_resp = 0;
            clear_exp();
            e_mem_resp = 1; e_way_sel = 2'(vict);
            if (is_wr) begin
                e_we = 4'(1 << vict); e_dload = 4'(1 << vict); e_ddin = 1; e_dds = 1;
            end
            step();
            model_touch(s, vict);
        end
        mem_read = 0; mem_write = 0; pmem_resp = 0;
        clear_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, f0;
        rst = 0; mem_read = 0; mem_write = 0; mem_address = 0;
        hit = 0; valid = 0; dirty = 0; pmem_resp = 0;
        for (int s = 0; s < SETS; s++) mtree[s] = '0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        clear_exp();
        chk_en = 1;
        #3;
        check("reset mem_resp", mem_resp, 0);
        check("reset hit_count", hit_count, 0);
        step(); step();
        rst = 1;
        step();

        // Read hit, way 2, set 3
        access(1, 0, 32'h0000_0060, 4'b0100, 4'b1111, 4'b0000, 0, 0, 0, v);
        check("rd_hit way_sel", cap_way_sel, 2);
        check("rd_hit hit_count", hit_count, 1);
        check("rd_hit model tree set3", mtree[3], 3'b100);

        // Write hit, way 1, set 1
        access(0, 1, 32'h0000_0024, 4'b0010, 4'b1111, 4'b0000, 0, 0, 0, v);
        check("wr_hit data_we", cap_data_we, 4'b0010);
        check("wr_hit dirty_load", cap_dirty_load, 4'b0010);

        // Clean miss into invalid way 3, 5-cycle fill
        f0 = fill_cyc;
        access(1, 0, 32'h0000_0040, 4'b0000, 4'b0111, 4'b0000, 0, 5, 0, v);
        check("clean_miss victim", v, 3);
        check("clean_miss tag_load", cap_tag_load, 4'b1000);
        check("clean_miss fill cycles", fill_cyc - f0, 5);

        // Full set, PLRU victim way 0 dirty
        access(1, 0, 32'h0000_00A0, 4'b0000, 4'b1111, 4'b0001, 3, 2, 0, v);
        check("dirty_miss victim", v, 0);
        check("dirty_miss wb_count", wb_count, 1);
        check("dirty_miss miss_count", miss_count, 2);

        // Ways 0..3 in order, then a clean full-set miss
        for (int w = 0; w < 4; w++)
            access(1, 0, 32'h0000_00C0, 4'(1 << w), 4'b1111, 4'b0000, 0, 0, 0, v);
        access(1, 0, 32'h0000_00C0, 4'b0000, 4'b1111, 4'b0000, 0, 2, 0, v);
        check("plru order victim", v, 0);
        check("plru order way_sel", cap_way_sel, 0);

        // Single touch of way 0 steers the victim to way 2
        access(1, 0, 32'h0000_00E0, 4'b0001, 4'b1111, 4'b0000, 0, 0, 0, v);
        access(1, 0, 32'h0000_00E0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 0, v);
        check("plru touch0 victim", v, 2);
        check("plru touch0 way_sel", cap_way_sel, 2);

        // Write miss on dirty full set with stray pmem_resp in IDLE/TAG_CHECK
        access(0, 1, 32'h0000_0080, 4'b0000, 4'b1111, 4'b1111, 1, 1, 1, v);
        check("wr_miss data_we", cap_data_we, 4'b0001);

        // Read and write together behave as a read; multiple hits pick the lowest
        access(1, 1, 32'h0000_0000, 4'b1000, 4'b1111, 4'b0000, 0, 0, 0, v);
        check("rd_wr data_we", cap_data_we, 4'b0000);
        access(1, 0, 32'h0000_0000, 4'b0110, 4'b1111, 4'b0000, 0, 0, 0, v);
        check("multi_hit way_sel", cap_way_sel, 1);
        check("hit_count saturated", hit_count, 7);

        // Asynchronous reset in the middle of a fill
        chk_en = 0;
        mem_read = 1; mem_address = 32'h0000_0020; hit = 0; valid = 0; dirty = 0;
        step();
        step();
        #1;
        check("pre-reset pmem_read", pmem_read, 1);
        rst = 0;
        #1;
        check("async reset pmem_read", pmem_read, 0);
        check("async reset mem_resp", mem_resp, 0);
        check("async reset miss_count", miss_count, 0);
        mem_read = 0;
        for (int s = 0; s < SETS; s++) mtree[s] = '0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        clear_exp();
        step();
        rst = 1;
        chk_en = 1;
        repeat (3) step();
        check("post-reset hit_count", hit_count, 0);
        check("post-reset wb_count", wb_count, 0);

        // Operation resumes from clean PLRU state
        access(1, 0, 32'h0000_0020, 4'b0000, 4'b1111, 4'b0000, 0, 1, 0, v);
        check("post-reset victim", cap_way_sel, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cache_control_nway
`default_nettype wire
